// File: rtl/nn_pkg.sv
// Shared widths, saturation limit, sequencer state encoding and the
// accumulate-term helpers for the neuron MAC sequencer.
package nn_pkg;

  localparam int ACC_W = 21;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SAT_MAX = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SAT   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Signed 8x8 product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] bias_term(input logic [DATA_W-1:0] b);
    return {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
  endfunction

endpackage

// File: rtl/relu_saturation.sv
// Clamps a signed accumulator to an 8-bit activation in 0..SAT_MAX.
module relu_saturation
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] act
);

  // Negative -> 0, anything with a bit at or above 2^7 -> SAT_MAX, else pass through.
  always_comb begin
    act = {DATA_W{1'b0}};
    if (acc[ACC_W-1]) begin
      act = {DATA_W{1'b0}};
    end else if (|acc[ACC_W-2:DATA_W-1]) begin
      act = SAT_MAX;
    end else begin
      act = acc[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Evaluates one MLP layer neuron by neuron on a shared MAC + ReLU-saturate
// datapath, streaming each activation out on a valid/ready port.
module neuron_mac_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = 62,
  parameter int NUM_NEURONS = 30,
  parameter int X_AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int W_AW = $clog2(NUM_NEURONS * (NUM_INPUTS + 1)),
  parameter int N_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [X_AW-1:0] x_addr,
  input  logic [7:0]      x_data,
  output logic [W_AW-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [N_W-1:0]  out_idx
);

  localparam int K_W = $clog2(NUM_INPUTS + 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(NUM_INPUTS);
  localparam logic [X_AW-1:0] X_LAST = X_AW'(NUM_INPUTS - 1);
  localparam logic [N_W-1:0]  N_LAST = N_W'(NUM_NEURONS - 1);

  state_t                   state_r;
  logic [K_W-1:0]           k_r;
  logic [N_W-1:0]           n_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     pipe_vld_r;
  logic [X_AW-1:0]          x_addr_r;
  logic [W_AW-1:0]          w_addr_r;
  logic                     out_valid_r;
  logic [DATA_W-1:0]        out_data_r;
  logic [N_W-1:0]           out_idx_r;
  logic                     busy_r;
  logic                     done_r;
  logic [DATA_W-1:0]        act_s;

  relu_saturation u_relu (
    .acc (acc_r),
    .act (act_s)
  );

  // Sequencer FSM plus the accumulate path, which lags address issue by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_r         <= {K_W{1'b0}};
      n_r         <= {N_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      pipe_vld_r  <= 1'b0;
      x_addr_r    <= {X_AW{1'b0}};
      w_addr_r    <= {W_AW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_idx_r   <= {N_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      // Flag set on every issue edge; in DRAIN the arriving word is the bias.
      pipe_vld_r <= (state_r == ST_ACCUM);
      if (pipe_vld_r) begin
        if (state_r == ST_DRAIN) begin
          acc_r <= acc_r + bias_term(w_data);
        end else begin
          acc_r <= acc_r + mac_term(x_data, w_data);
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_ACCUM;
            busy_r   <= 1'b1;
            k_r      <= {K_W{1'b0}};
            n_r      <= {N_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            x_addr_r <= {X_AW{1'b0}};
            w_addr_r <= {W_AW{1'b0}};
          end
        end
        ST_ACCUM: begin
          k_r <= k_r + K_W'(1'b1);
          if (k_r == K_LAST) begin
            state_r <= ST_DRAIN;
          end else begin
            w_addr_r <= w_addr_r + W_AW'(1'b1);
            if (x_addr_r != X_LAST) begin
              x_addr_r <= x_addr_r + X_AW'(1'b1);
            end
          end
        end
        ST_DRAIN: begin
          state_r <= ST_SAT;
        end
        ST_SAT: begin
          out_data_r  <= act_s;
          out_idx_r   <= n_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (n_r != N_LAST) begin
              // Next neuron's weights start right after this neuron's bias word.
              n_r      <= n_r + N_W'(1'b1);
              k_r      <= {K_W{1'b0}};
              acc_r    <= {ACC_W{1'b0}};
              x_addr_r <= {X_AW{1'b0}};
              w_addr_r <= w_addr_r + W_AW'(1'b1);
              state_r  <= ST_ACCUM;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign x_addr    = x_addr_r;
  assign w_addr    = w_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench: behavioural layer model + scoreboard monitor for neuron_mac_sequencer.
module tb_neuron_mac_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;

  logic       clk, rst_n, start, out_ready;
  logic       busy, done, out_valid;
  logic [1:0] x_addr;
  logic [3:0] w_addr;
  logic [7:0] x_data, w_data, out_data;
  logic [1:0] out_idx;

  logic [7:0] xmem [4];
  logic [7:0] wmem [16];

  int errors = 0;
  int checks = 0;
  int exp_d_q[$];
  int exp_i_q[$];
  int done_cnt = 0;
  int hs_cnt = 0;
  bit prev_v = 1'b0;
  bit prev_hs = 1'b0;
  int prev_d = 0;
  int prev_i = 0;

  neuron_mac_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // Synchronous read memories with one cycle of latency.
  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_acc(input int n);
    int acc = 0;
    byte xv, wv;
    for (int i = 0; i < NI; i++) begin
      xv = xmem[i];
      wv = wmem[n * (NI + 1) + i];
      acc = acc + xv * wv;
    end
    wv = wmem[n * (NI + 1) + NI];
    return acc + wv;
  endfunction

  function automatic int clamp(input int a);
    if (a > 127) return 127;
    if (a < 0) return 0;
    return a;
  endfunction

  task automatic set_x(input int a, input int b, input int c, input int d);
    xmem[0] = 8'(a); xmem[1] = 8'(b); xmem[2] = 8'(c); xmem[3] = 8'(d);
  endtask

  task automatic set_n(input int n, input int w0, input int w1, input int w2, input int w3, input int b);
    wmem[n*5+0] = 8'(w0); wmem[n*5+1] = 8'(w1); wmem[n*5+2] = 8'(w2);
    wmem[n*5+3] = 8'(w3); wmem[n*5+4] = 8'(b);
  endtask

  task automatic push_expect();
    for (int n = 0; n < NN; n++) begin
      exp_d_q.push_back(clamp(model_acc(n)));
      exp_i_q.push_back(n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
    chk(done == 1'b0, {tag, "_done"}, int'(done), 0);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, int'(out_valid), 0);
    chk(out_data == 8'd0, {tag, "_out_data"}, int'(out_data), 0);
    chk(out_idx == 2'd0, {tag, "_out_idx"}, int'(out_idx), 0);
    chk(x_addr == 2'd0, {tag, "_x_addr"}, int'(x_addr), 0);
    chk(w_addr == 4'd0, {tag, "_w_addr"}, int'(w_addr), 0);
  endtask

  // Scoreboard: every valid cycle must match the head of the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        chk(exp_d_q.size() > 0, "unexpected_valid", int'(out_idx), -1);
        if (exp_d_q.size() > 0) begin
          chk(int'(out_data) == exp_d_q[0], "out_data", int'(out_data), exp_d_q[0]);
          chk(int'(out_idx) == exp_i_q[0], "out_idx", int'(out_idx), exp_i_q[0]);
        end
        chk(busy == 1'b1, "busy_while_valid", int'(busy), 1);
        if (prev_v && !prev_hs) begin
          chk(int'(out_data) == prev_d && int'(out_idx) == prev_i, "hold_stable",
              int'(out_data), prev_d);
        end
        if (out_ready) begin
          if (exp_d_q.size() > 0) begin
            void'(exp_d_q.pop_front());
            void'(exp_i_q.pop_front());
          end
          hs_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        chk(prev_hs && exp_d_q.size() == 0, "done_after_last", exp_d_q.size(), 0);
      end
      prev_v = out_valid;
      prev_hs = out_valid && out_ready;
      prev_d = int'(out_data);
      prev_i = int'(out_idx);
    end
  end

  // mode 0: always ready, 1: stall neuron 1 for 5 cycles, 2: random ready
  task automatic run_pass(input int mode, input bit hold, input bit pin_en,
                          input int p0, input int p1, input int p2);
    int pins[3];
    int d0, h0, cyc, first, bp;
    bit fin;
    pins[0] = p0; pins[1] = p1; pins[2] = p2;
    if (pin_en) begin
      for (int n = 0; n < NN; n++) begin
        chk(clamp(model_acc(n)) == pins[n], "model_pin", clamp(model_acc(n)), pins[n]);
      end
    end
    push_expect();
    d0 = done_cnt; h0 = hs_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 0; first = -1; bp = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      if (out_valid && first < 0) first = cyc;
      if (mode == 1) begin
        if (out_valid && out_idx == 2'd1 && bp < 5) begin
          out_ready = 1'b0; bp++;
        end else begin
          out_ready = 1'b1;
        end
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk(fin, "done_seen", int'(fin), 1);
    chk(first == NI + 3, "latency", first, NI + 3);
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(hs_cnt - h0 == NN, "handshake_count", hs_cnt - h0, NN);
    chk(exp_d_q.size() == 0, "all_outputs_seen", exp_d_q.size(), 0);
    chk(busy == 1'b0 && done == 1'b0, "idle_after_done", int'(busy), 0);
    if (mode == 1) chk(bp == 5, "backpressure_applied", bp, 5);
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk(busy == 1'b0, "no_restart", int'(busy), 0);
    exp_d_q.delete();
    exp_i_q.delete();
  endtask

  task automatic reset_mid_pass();
    int h0, cnt;
    push_expect();
    h0 = hs_cnt;
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (hs_cnt == h0 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(hs_cnt > h0, "n0_handshake_before_reset", hs_cnt - h0, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_d_q.delete();
    exp_i_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk(busy == 1'b0 && out_valid == 1'b0, "idle_after_reset", int'(busy), 0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    x_data = 8'd0; w_data = 8'd0;
    for (int i = 0; i < 16; i++) wmem[i] = 8'd0;
    set_x(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    set_x(1, 2, 3, 4);
    set_n(0, 1, 1, 1, 1, 0);
    set_n(1, 0, 0, 0, 0, 3);
    set_n(2, 0, 0, 0, 32, 0);
    run_pass(1, 1'b1, 1'b1, 10, 3, 127);

    set_x(10, 10, 10, 10);
    set_n(0, -5, -5, -5, -5, 3);
    set_n(1, 0, 0, 0, 0, -1);
    set_n(2, 127, 127, 127, 127, 127);
    chk(model_acc(0) == -197, "model_acc_neg", model_acc(0), -197);
    run_pass(0, 1'b0, 1'b1, 0, 0, 127);

    set_x(127, 127, 127, 127);
    set_n(0, 127, 127, 127, 127, 127);
    set_n(1, -128, -128, -128, -128, -128);
    set_n(2, 1, 0, 0, 0, 0);
    chk(model_acc(0) == 64643, "model_acc_pos", model_acc(0), 64643);
    run_pass(2, 1'b0, 1'b1, 127, 0, 127);

    reset_mid_pass();
    run_pass(0, 1'b0, 1'b1, 127, 0, 127);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) xmem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < NN * (NI + 1); i++) wmem[i] = 8'($urandom_range(0, 255));
      run_pass(2, 1'(r % 2), 1'b0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
